// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring sequence checker.
// Holds the FSM state enum, rotate/one-hot helpers and index-width derivation.
package ring_pkg;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  localparam int MAXW = 64;
  localparam int IXW = 6;

  typedef logic [MAXW-1:0] word_t;

  function automatic int idx_w(int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Rotate left within the low w bits of x.
  function automatic word_t rotl(word_t x, int w);
    word_t r;
    r = '0;
    for (int i = 1; i < MAXW; i++)
      if (i < w) r[i] = x[i-1];
    r[0] = x[IXW'(w - 1)];
    return r;
  endfunction

  // Rotate right within the low w bits of x.
  function automatic word_t rotr(word_t x, int w);
    word_t r;
    r = '0;
    for (int i = 0; i < MAXW - 1; i++)
      if (i < w - 1) r[i] = x[i+1];
    r[IXW'(w - 1)] = x[0];
    return r;
  endfunction

  function automatic logic onehot(word_t x, int w);
    int n;
    n = 0;
    for (int i = 0; i < MAXW; i++)
      if (i < w && x[i]) n = n + 1;
    return n == 1;
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder with a one-hot validity flag.
// Ports: d (WIDTH word in), idx (IW binary position), vld (exactly one bit set).
module onehot_to_bin
  import ring_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] d,
  output logic [IW-1:0]    idx,
  output logic             vld
);

  // OR of set-bit positions; only meaningful when vld is high.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (d[i]) idx = idx | IW'(i);
  end

  assign vld = onehot(word_t'(d), WIDTH);

endmodule

// File: rtl/ring_sequence_checker.sv
// Receive-side checker/decoder for a one-hot ring-counter sequence.
// Ports: CLK, RST (async, active-high), IN_VLD, D, CLR in;
//   IDX, IDX_VLD, LOCKED, ERR, ERR_CNT out (DIR with RING_CHK_DIR_AUTO_EN).
// Build option: define RING_CHK_DIR_AUTO_EN to auto-detect rotation direction.
module ring_sequence_checker
  import ring_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_CW   = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VLD,
  input  logic [WIDTH-1:0]          D,
  input  logic                      CLR,
  output logic [idx_w(WIDTH)-1:0]   IDX,
  output logic                      IDX_VLD,
  output logic                      LOCKED,
  output logic                      ERR,
`ifdef RING_CHK_DIR_AUTO_EN
  output logic                      DIR,
`endif
  output logic [ERR_CW-1:0]         ERR_CNT
);

  localparam int IW = idx_w(WIDTH);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  localparam logic [GW-1:0] GOOD_ONE = GW'(1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_ONE = MW'(1);
  localparam logic [MW-1:0] MISS_MAX = MW'(LOSS_CNT);
  localparam logic [ERR_CW-1:0] CNT_MAX = '1;

  state_t           state, state_n;
  logic [WIDTH-1:0] exp_q, exp_n;
  logic [GW-1:0]    good_q, good_n;
  logic [MW-1:0]    miss_q, miss_n;
  logic             dir_q;

  logic [IW-1:0]    d_idx;
  logic             d_oh;

  logic             hit;
  logic             miss_ev;
  logic             acc;
  logic             acc_dir;

  logic [IW-1:0]     idx_n;
  logic              idx_vld_n;
  logic              locked_n;
  logic              err_n;
  logic [ERR_CW-1:0] cnt_n;

  onehot_to_bin #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_enc (
    .d   (D),
    .idx (d_idx),
    .vld (d_oh)
  );

  // Advance a word one position in the given direction (0 = left).
  function automatic logic [WIDTH-1:0] step(logic [WIDTH-1:0] x, logic r);
    if (r) return WIDTH'(rotr(word_t'(x), WIDTH));
    return WIDTH'(rotl(word_t'(x), WIDTH));
  endfunction

`ifdef RING_CHK_DIR_AUTO_EN
  logic dir_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) dir_q <= 1'b0;
    else     dir_q <= dir_n;
  end

  assign DIR = dir_q;
`else
  assign dir_q = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_HUNT;
      exp_q  <= '0;
      good_q <= '0;
      miss_q <= '0;
    end else begin
      state  <= state_n;
      exp_q  <= exp_n;
      good_q <= good_n;
      miss_q <= miss_n;
    end
  end

  always_comb begin
    state_n = state;
    exp_n   = exp_q;
    good_n  = good_q;
    miss_n  = miss_q;
`ifdef RING_CHK_DIR_AUTO_EN
    dir_n   = dir_q;
`endif
    hit     = 1'b0;
    miss_ev = 1'b0;
    acc     = 1'b0;
    acc_dir = dir_q;
    if (IN_VLD) begin
      unique case (state)
        ST_HUNT: begin
          if (d_oh) begin
            exp_n  = step(D, 1'b0);
            good_n = GOOD_ONE;
            miss_n = '0;
`ifdef RING_CHK_DIR_AUTO_EN
            dir_n  = 1'b0;
`endif
            state_n = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          acc = (D == exp_q);
`ifdef RING_CHK_DIR_AUTO_EN
          // Second sample may instead be a right rotation of the first.
          if (!acc && good_q == GOOD_ONE &&
              D == step(step(exp_q, 1'b1), 1'b1)) begin
            acc     = 1'b1;
            acc_dir = 1'b1;
          end
`endif
          if (acc) begin
            good_n = good_q + GOOD_ONE;
            exp_n  = step(D, acc_dir);
`ifdef RING_CHK_DIR_AUTO_EN
            dir_n  = acc_dir;
`endif
            if (good_n == GOOD_MAX) state_n = ST_LOCKED;
          end else if (d_oh) begin
            good_n = GOOD_ONE;
            exp_n  = step(D, 1'b0);
`ifdef RING_CHK_DIR_AUTO_EN
            dir_n  = 1'b0;
`endif
          end else begin
            good_n  = '0;
            state_n = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          // Flywheel: expected word advances whether or not D matched.
          exp_n = step(exp_q, dir_q);
          if (D == exp_q) begin
            hit    = 1'b1;
            miss_n = '0;
          end else begin
            miss_ev = 1'b1;
            if (miss_q + MISS_ONE == MISS_MAX) begin
              miss_n  = '0;
              good_n  = '0;
              state_n = ST_HUNT;
            end else begin
              miss_n = miss_q + MISS_ONE;
            end
          end
        end
        default: state_n = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    idx_n     = hit ? d_idx : IDX;
    idx_vld_n = hit;
    err_n     = miss_ev;
    locked_n  = (state_n == ST_LOCKED);
    cnt_n     = ERR_CNT;
    if (CLR)
      cnt_n = '0;
    else if (miss_ev && ERR_CNT != CNT_MAX)
      cnt_n = ERR_CNT + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IDX     <= '0;
      IDX_VLD <= 1'b0;
      LOCKED  <= 1'b0;
      ERR     <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      IDX     <= idx_n;
      IDX_VLD <= idx_vld_n;
      LOCKED  <= locked_n;
      ERR     <= err_n;
      ERR_CNT <= cnt_n;
    end
  end

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Self-checking bench for ring_sequence_checker.
// Instance A uses defaults; instance B uses LOCK_CNT=1, LOSS_CNT=8, ERR_CW=2.
module tb_ring_sequence_checker;

  typedef struct packed {
    logic       vld;
    logic [3:0] d;
    logic       clr;
    logic [1:0] idx;
    logic       iv;
    logic       lk;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  logic       clk;
  logic       rst_a;
  logic       rst_b;
  logic       vld;
  logic       clr;
  logic [3:0] d;

  logic [1:0] idx_a;
  logic       iv_a;
  logic       lk_a;
  logic       err_a;
  logic [7:0] cnt_a;

  logic [1:0] idx_b;
  logic       iv_b;
  logic       lk_b;
  logic       err_b;
  logic [1:0] cnt_b;

`ifdef RING_CHK_DIR_AUTO_EN
  logic dir_a;
  logic dir_b;
`endif

  int errors = 0;
  int checks = 0;

  vec_t sb[$];
  vec_t ta[$];
  vec_t tb[$];
  vec_t tr[$];

  ring_sequence_checker u_a (
    .CLK     (clk),
    .RST     (rst_a),
    .IN_VLD  (vld),
    .D       (d),
    .CLR     (clr),
    .IDX     (idx_a),
    .IDX_VLD (iv_a),
    .LOCKED  (lk_a),
    .ERR     (err_a),
`ifdef RING_CHK_DIR_AUTO_EN
    .DIR     (dir_a),
`endif
    .ERR_CNT (cnt_a)
  );

  ring_sequence_checker #(
    .LOCK_CNT (1),
    .LOSS_CNT (8),
    .ERR_CW   (2)
  ) u_b (
    .CLK     (clk),
    .RST     (rst_b),
    .IN_VLD  (vld),
    .D       (d),
    .CLR     (clr),
    .IDX     (idx_b),
    .IDX_VLD (iv_b),
    .LOCKED  (lk_b),
    .ERR     (err_b),
`ifdef RING_CHK_DIR_AUTO_EN
    .DIR     (dir_b),
`endif
    .ERR_CNT (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int v, int dd, int c, int ix, int iv,
                              int lk, int er, int cn);
    vec_t r;
    r.vld = 1'(v);
    r.d   = 4'(dd);
    r.clr = 1'(c);
    r.idx = 2'(ix);
    r.iv  = 1'(iv);
    r.lk  = 1'(lk);
    r.err = 1'(er);
    r.cnt = 8'(cn);
    return r;
  endfunction

  task automatic check(string nm, vec_t e, bit sel);
    logic [1:0] ai;
    logic       aiv, alk, aer;
    logic [7:0] ac;
    if (sel) begin
      ai = idx_b; aiv = iv_b; alk = lk_b; aer = err_b; ac = {6'b0, cnt_b};
    end else begin
      ai = idx_a; aiv = iv_a; alk = lk_a; aer = err_a; ac = cnt_a;
    end
    checks++;
    if ({ai, aiv, alk, aer, ac} !== {e.idx, e.iv, e.lk, e.err, e.cnt}) begin
      errors++;
      $display("FAIL %s: got idx=%0d idx_vld=%0b locked=%0b err=%0b cnt=%0d, want idx=%0d idx_vld=%0b locked=%0b err=%0b cnt=%0d",
               nm, ai, aiv, alk, aer, ac,
               e.idx, e.iv, e.lk, e.err, e.cnt);
    end
  endtask

  task automatic apply(vec_t v, bit sel, string nm);
    @(negedge clk);
    vld = v.vld;
    d   = v.d;
    clr = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check(nm, sb.pop_front(), sel);
  endtask

  initial begin
    vld = 1'b0; d = '0; clr = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;

    // Instance A: acquire, decode, glitch, loss, relock
    ta.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 0, 0));
    ta.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 0, 0));
    ta.push_back(mk(1, 4'b0100, 0, 0, 0, 1, 0, 0));
    ta.push_back(mk(1, 4'b1000, 0, 3, 1, 1, 0, 0));
    ta.push_back(mk(1, 4'b0001, 0, 0, 1, 1, 0, 0));
    ta.push_back(mk(1, 4'b0010, 0, 1, 1, 1, 0, 0));
    ta.push_back(mk(1, 4'b0110, 0, 1, 0, 1, 1, 1));
    ta.push_back(mk(1, 4'b1000, 0, 3, 1, 1, 0, 1));
    ta.push_back(mk(1, 4'b0000, 0, 3, 0, 1, 1, 2));
    ta.push_back(mk(1, 4'b0000, 0, 3, 0, 0, 1, 3));
    ta.push_back(mk(1, 4'b0001, 0, 3, 0, 0, 0, 3));
    ta.push_back(mk(1, 4'b0010, 0, 3, 0, 0, 0, 3));
    ta.push_back(mk(1, 4'b0100, 0, 3, 0, 1, 0, 3));
    ta.push_back(mk(1, 4'b0000, 0, 3, 0, 1, 1, 4));
    ta.push_back(mk(1, 4'b0000, 0, 3, 0, 0, 1, 5));
    // HUNT ignores multi-bit; VERIFY drops on non-one-hot; restart
    ta.push_back(mk(1, 4'b0011, 0, 3, 0, 0, 0, 5));
    ta.push_back(mk(1, 4'b0001, 0, 3, 0, 0, 0, 5));
    ta.push_back(mk(1, 4'b0000, 0, 3, 0, 0, 0, 5));
    ta.push_back(mk(1, 4'b0001, 0, 3, 0, 0, 0, 5));
    ta.push_back(mk(1, 4'b0010, 0, 3, 0, 0, 0, 5));
    ta.push_back(mk(1, 4'b1000, 0, 3, 0, 0, 0, 5));
    ta.push_back(mk(1, 4'b0001, 0, 3, 0, 0, 0, 5));
    ta.push_back(mk(1, 4'b0010, 0, 3, 0, 1, 0, 5));
    // Valid gaps hold everything
    for (int i = 0; i < 5; i++)
      ta.push_back(mk(0, 4'b1111, 0, 3, 0, 1, 0, 5));
    ta.push_back(mk(1, 4'b0100, 0, 2, 1, 1, 0, 5));
    // CLR beats coincident error; ERR still pulses
    ta.push_back(mk(1, 4'b0001, 1, 2, 0, 1, 1, 0));
    ta.push_back(mk(1, 4'b0001, 0, 0, 1, 1, 0, 0));
    ta.push_back(mk(1, 4'b1111, 0, 0, 0, 1, 1, 1));
    ta.push_back(mk(0, 4'b0000, 1, 0, 0, 1, 0, 0));
    ta.push_back(mk(1, 4'b0100, 0, 2, 1, 1, 0, 0));
    ta.push_back(mk(1, 4'b0000, 0, 2, 0, 1, 1, 1));

    // After async reset: fresh acquisition
    tr.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 0, 0));
    tr.push_back(mk(1, 4'b0100, 0, 0, 0, 0, 0, 0));
    tr.push_back(mk(1, 4'b1000, 0, 0, 0, 1, 0, 0));

    // Instance B: direct lock, saturation without loss, clear
    tb.push_back(mk(1, 4'b0001, 0, 0, 0, 1, 0, 0));
    tb.push_back(mk(1, 4'b0010, 0, 1, 1, 1, 0, 0));
    tb.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 1, 1));
    tb.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 1, 2));
    tb.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 1, 3));
    tb.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 1, 3));
    tb.push_back(mk(1, 4'b0000, 0, 1, 0, 1, 1, 3));
    tb.push_back(mk(1, 4'b1000, 0, 3, 1, 1, 0, 3));
    tb.push_back(mk(0, 4'b0000, 1, 3, 0, 1, 0, 0));
    tb.push_back(mk(1, 4'b0001, 0, 0, 1, 1, 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("A_reset", mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    for (int i = 0; i < ta.size(); i++)
      apply(ta[i], 1'b0, $sformatf("A_vec%0d", i));

    // Asynchronous reset mid-lock, between clock edges
    #3;
    rst_a = 1'b1;
    #1;
    check("A_async_rst", mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    @(negedge clk);
    vld = 1'b0;
    rst_a = 1'b0;

    for (int i = 0; i < tr.size(); i++)
      apply(tr[i], 1'b0, $sformatf("A_relock%0d", i));

    @(negedge clk);
    vld = 1'b0;
    clr = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b0;
    #1;
    check("B_reset", mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1);

    for (int i = 0; i < tb.size(); i++)
      apply(tb[i], 1'b1, $sformatf("B_vec%0d", i));

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
